// File: rtl/aes256_encrypt_iter.sv
// aes256_encrypt_iter: iterative AES-256 cipher, one round per clock.
// Define AES_ENC_KEY_LATCH_EN to capture all round keys at accept.
module aes256_encrypt_iter #(
    parameter int NUM_ROUNDS = 14
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [1919:0] round_key_i,
    input  logic          v_i,
    output logic          ready_o,
    input  logic [127:0]  data_i,
    output logic          v_o,
    output logic [127:0]  data_o,
    input  logic          yumi_i,
    output logic          busy_o
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as inverse (a^254, which also maps 0 to 0) plus affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]}
                   ^ 8'h63;
    endfunction

    state_e        state_q, state_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [127:0]  blk_q, blk_d;
    logic [1919:0] rk_all;
    logic [127:0]  rk_sel;
    logic [127:0]  sub_s;
    logic [127:0]  shf_s;
    logic [127:0]  mix_s;
    logic [127:0]  rnd_out;
    logic [7:0]    a0, a1, a2, a3;

`ifdef AES_ENC_KEY_LATCH_EN
    logic [1919:0] key_q, key_d;
    assign rk_all = key_q;
`else
    assign rk_all = round_key_i;
`endif

    // One cipher round on the held state; MixColumns dropped on the last
    always_comb begin
        rk_sel = rk_all[{rnd_q, 7'd0} +: 128];
        sub_s  = '0;
        shf_s  = '0;
        mix_s  = '0;
        a0     = '0;
        a1     = '0;
        a2     = '0;
        a3     = '0;
        for (int b = 0; b < 16; b++) begin
            sub_s[127-8*b -: 8] = sbox(blk_q[127-8*b -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf_s[127-8*(4*c+r) -: 8] =
                    sub_s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = shf_s[127-8*(4*c)   -: 8];
            a1 = shf_s[127-8*(4*c+1) -: 8];
            a2 = shf_s[127-8*(4*c+2) -: 8];
            a3 = shf_s[127-8*(4*c+3) -: 8];
            mix_s[127-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mix_s[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mix_s[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mix_s[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        rnd_out = ((rnd_q == LAST_RND) ? shf_s : mix_s) ^ rk_sel;
    end

    // Next-state, datapath load and handshake outputs
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        ready_o = 1'b0;
        v_o     = 1'b0;
        busy_o  = 1'b0;
        data_o  = '0;
`ifdef AES_ENC_KEY_LATCH_EN
        key_d   = key_q;
`endif
        unique case (state_q)
            IDLE: begin
                ready_o = ~reset_i;
                if (v_i) begin
                    blk_d   = data_i ^ round_key_i[127:0];
                    rnd_d   = 4'd1;
                    state_d = ROUND;
`ifdef AES_ENC_KEY_LATCH_EN
                    key_d   = round_key_i;
`endif
                end
            end
            ROUND: begin
                busy_o = 1'b1;
                blk_d  = rnd_out;
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) state_d = DONE;
            end
            DONE: begin
                v_o    = 1'b1;
                data_o = blk_q;
                if (yumi_i) begin
                    state_d = IDLE;
                    rnd_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round counter and cipher state registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            blk_q   <= '0;
`ifdef AES_ENC_KEY_LATCH_EN
            key_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
`ifdef AES_ENC_KEY_LATCH_EN
            key_q   <= key_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes256_encrypt_iter.sv
// tb_aes256_encrypt_iter: random and FIPS-197 C.3 checks of the
// iterative AES-256 core against a byte-array reference model.
module tb_aes256_encrypt_iter;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [255:0] C3_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [1919:0] round_key_i;
    logic          v_i;
    logic          ready_o;
    logic [127:0]  data_i;
    logic          v_o;
    logic [127:0]  data_o;
    logic          yumi_i;
    logic          busy_o;

    int n_chk = 0;
    int n_bad = 0;

    aes256_encrypt_iter #(.NUM_ROUNDS(14)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .round_key_i (round_key_i),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .v_o         (v_o),
        .data_o      (data_o),
        .yumi_i      (yumi_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        int i;
        i = int'(x);
        return SBOX[2047-8*i -: 8];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] enc(input logic [1919:0] rk,
                                         input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k;
        logic [127:0] out;
        k = rk[127:0];
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ k[127-8*b -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int b = 0; b < 16; b++) t[b] = sb(s[b]);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[4*c+w] = t[4*((c+w)%4)+w];
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    for (int w = 0; w < 4; w++) t[w] = s[4*c+w];
                    for (int w = 0; w < 4; w++)
                        s[4*c+w] = gmul(t[w], 8'h02) ^ gmul(t[(w+1)%4], 8'h03)
                                 ^ t[(w+2)%4] ^ t[(w+3)%4];
                end
            end
            k = rk[128*r +: 128];
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ k[127-8*b -: 8];
        end
        for (int b = 0; b < 16; b++) out[127-8*b -: 8] = s[b];
        return out;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic encrypt(input logic [1919:0] rk, input logic [127:0] pt,
                           input bit noise, input bit zero_key,
                           output logic [127:0] ct, output int lat);
        round_key_i = rk;
        data_i      = pt;
        chk("ready_idle", 128'(ready_o), 128'(1));
        v_i = 1'b1;
        tick();
        v_i    = 1'b0;
        data_i = rnd128();
        if (zero_key) round_key_i = '0;
        lat = 1;
        while (!v_o && lat < 40) begin
            if (noise) begin
                v_i    = (lat >= 3 && lat <= 11);
                data_i = rnd128();
            end
            tick();
            lat++;
        end
        v_i    = 1'b0;
        ct     = data_o;
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
    endtask

    logic [1919:0] rk_c3;
    logic [1919:0] rk;
    logic [127:0]  ct;
    logic [127:0]  pt;
    logic [127:0]  pt2;
    logic [127:0]  outs [4];
    int            acc_cyc [4];
    int            lat;
    int            n_acc;
    int            n_out;

    initial begin
        reset_i     = 1'b1;
        v_i         = 1'b0;
        yumi_i      = 1'b0;
        data_i      = '0;
        rk_c3       = expand(C3_KEY);
        round_key_i = rk_c3;
        repeat (3) tick();
        chk("rst_ready", 128'(ready_o), 128'(0));
        chk("rst_v_o", 128'(v_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_data", data_o, 128'(0));
        reset_i = 1'b0;
        tick();
        chk("idle_data", data_o, 128'(0));

        // FIPS-197 C.3
        encrypt(rk_c3, C3_PT, 1'b0, 1'b0, ct, lat);
        chk("c3_ct", ct, C3_CT);
        chk("c3_lat", 128'(lat), 128'(15));
        chk("c3_after_v_o", 128'(v_o), 128'(0));

        // backpressure
        round_key_i = rk_c3;
        data_i      = C3_PT;
        v_i         = 1'b1;
        tick();
        v_i = 1'b0;
        lat = 1;
        while (!v_o && lat < 40) begin
            chk("bp_data_zero", data_o, 128'(0));
            tick();
            lat++;
        end
        chk("bp_lat", 128'(lat), 128'(15));
        for (int i = 0; i < 10; i++) begin
            chk("bp_v_o", 128'(v_o), 128'(1));
            chk("bp_data", data_o, C3_CT);
            chk("bp_ready", 128'(ready_o), 128'(0));
            tick();
        end
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        chk("bp_pop_v_o", 128'(v_o), 128'(0));
        chk("bp_pop_ready", 128'(ready_o), 128'(1));
        chk("bp_pop_data", data_o, 128'(0));

        // back-to-back with v_i and yumi_i held high
        pt     = rnd128();
        pt2    = rnd128();
        data_i = pt;
        v_i    = 1'b1;
        yumi_i = 1'b1;
        n_acc  = 0;
        n_out  = 0;
        for (int c = 0; c < 60; c++) begin
            if (v_o) begin
                if (n_out < 4) outs[n_out] = data_o;
                n_out++;
            end
            if (v_i && ready_o) begin
                if (n_acc < 4) acc_cyc[n_acc] = c;
                n_acc++;
            end
            tick();
            if (n_acc == 1) data_i = pt2;
            if (n_acc == 2) v_i = 1'b0;
        end
        yumi_i = 1'b0;
        v_i    = 1'b0;
        chk("b2b_accepts", 128'(n_acc), 128'(2));
        chk("b2b_outs", 128'(n_out), 128'(2));
        if (n_acc >= 2)
            chk("b2b_gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'(16));
        if (n_out >= 2) begin
            chk("b2b_ct0", outs[0], enc(rk_c3, pt));
            chk("b2b_ct1", outs[1], enc(rk_c3, pt2));
        end

        // reset during round 7
        data_i = C3_PT;
        v_i    = 1'b1;
        tick();
        v_i = 1'b0;
        repeat (6) tick();
        chk("mid_busy", 128'(busy_o), 128'(1));
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        chk("mid_v_o", 128'(v_o), 128'(0));
        chk("mid_busy_clr", 128'(busy_o), 128'(0));
        chk("mid_ready", 128'(ready_o), 128'(1));
        encrypt(rk_c3, C3_PT, 1'b0, 1'b0, ct, lat);
        chk("mid_c3_ct", ct, C3_CT);

        // v_i with other data during rounds is ignored
        encrypt(rk_c3, C3_PT, 1'b1, 1'b0, ct, lat);
        chk("noise_ct", ct, C3_CT);
        chk("noise_lat", 128'(lat), 128'(15));

`ifdef AES_ENC_KEY_LATCH_EN
        encrypt(rk_c3, C3_PT, 1'b0, 1'b1, ct, lat);
        chk("latch_ct", ct, C3_CT);
`endif

        // random keys and blocks
        for (int i = 0; i < 8; i++) begin
            rk = expand({rnd128(), rnd128()});
            pt = rnd128();
            encrypt(rk, pt, i[0], 1'b0, ct, lat);
            chk("rand_ct", ct, enc(rk, pt));
            chk("rand_lat", 128'(lat), 128'(15));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/aes256_encrypt_iter.md
Name: aes256_encrypt_iter

Overview:
Iterative AES-256 encryption core that consumes the 15 round keys produced by the key expansion stage and encrypts one 128-bit block at a time. It performs one round per clock: initial AddRoundKey at accept, then 13 full rounds and a final round with no MixColumns. It sits directly downstream of key expansion and upstream of the chip's output/packing logic, with a valid/ready input and a valid/yumi output.

Parameters:
NUM_ROUNDS, 14, number of cipher rounds. Fixed for AES-256; any other value is unsupported.

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
round_key_i  input  1920  round key i at bits [128*i +: 128], i=0..14; bit 127 of each slice is the MSB of byte 0
v_i  input  1  plaintext valid
ready_o  output  1  core can accept a block
data_i  input  128  plaintext; bits [127:120] = byte 0 (state column 0, row 0), column-major
v_o  output  1  ciphertext valid
data_o  output  128  ciphertext, same byte order as data_i
yumi_i  input  1  consumer takes data_o this cycle; legal only when v_o=1
busy_o  output  1  high in ROUND state

Behaviour:
- FSM states: IDLE, ROUND, DONE. Encoded in a register; reset to IDLE.
- Reset: state=IDLE, round counter=0, state register=0, v_o=0, busy_o=0. ready_o=0 while reset_i=1; in IDLE otherwise ready_o=1. Reset mid-operation aborts the block silently; no output is produced.
- IDLE: ready_o=1. On v_i&ready_o: state_reg <= data_i ^ rk0, rnd <= 1, go to ROUND.
- ROUND: each cycle state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), rk[rnd]). When rnd==14, MixColumns is skipped. rnd increments by 1 per cycle. After the rnd==14 cycle, go to DONE.
- DONE: v_o=1 and data_o=state_reg, both held stable until yumi_i. On yumi_i, go to IDLE. ready_o stays 0 in DONE, so there is no same-cycle accept; the next block can be accepted on the following cycle.
- Latency: handshake at cycle T gives v_o=1 at cycle T+15. Throughput is one block per 16 cycles minimum with yumi_i tied high.
- v_i in ROUND/DONE is ignored (ready_o=0). yumi_i when v_o=0 is a protocol violation; the core ignores it.
- SubBytes uses a 256-entry S-box function inside the block, 16 instances, combinational within the round cycle. MixColumns uses xtime over GF(2^8) with polynomial 0x11B.
- round_key_i must be held stable from accept until v_o rises, unless AES_ENC_KEY_LATCH_EN is defined.
- data_o is 0 outside DONE.

Optional Feature:
AES_ENC_KEY_LATCH_EN
- Defined: on accept, all 1920 bits of round_key_i are captured into an internal register. Rounds use the latched copy, so upstream may change keys immediately after the accept cycle. The latch is cleared to 0 on reset.
- Undefined: no key register. Rounds read round_key_i live; the stability requirement above applies.

Test Plan:
- FIPS-197 C.3: key 000102…1f (rk0=000102…0f, rk1=101112…1f, rest per expansion), data_i=00112233445566778899aabbccddeeff -> v_o at T+15, data_o=8ea2b7ca516745bfeafc49904b496089.
- Backpressure: same vector, yumi_i held low 10 cycles after v_o -> data_o and v_o stable throughout, ready_o=0; yumi_i pulse -> next cycle v_o=0, ready_o=1.
- Back-to-back: two vectors with v_i held high and yumi_i tied 1 -> accepts exactly 16 cycles apart, both ciphertexts correct, no extra outputs.
- Reset mid-op: reset_i pulsed at round 7 -> next cycle state IDLE, v_o=0, busy_o=0, ready_o=1. A fresh C.3 encrypt then gives the correct ciphertext.
- Ignored input: v_i with alternate data asserted during ROUND -> no effect on result; ciphertext still 8ea2b7ca….
- AES_ENC_KEY_LATCH_EN defined: round_key_i driven to all-0 the cycle after accept -> ciphertext still 8ea2b7ca516745bfeafc49904b496089. With the macro undefined, the same stimulus is not a legal case and is not checked.
